// File: rtl/alu_16bit_resp_checker.sv
// Response checker for the 16-bit ALU: golden model, latency-aligned compare, counters,
// first-failure capture and sticky alarm. Define CHECKER_FLAGS_EN to also compare flags.
module alu_16bit_resp_checker #(
  parameter int unsigned LAT          = 1,
  parameter int unsigned ALARM_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [1:0]  op,
  input  logic [15:0] dut_result,
  input  logic        dut_carry,
  input  logic        dut_zero,
  input  logic        dut_overflow,
  input  logic        dut_negative,
  output logic [31:0] check_cnt,
  output logic [15:0] mism_cnt,
  output logic        alarm,
  output logic        fail_valid,
  output logic [15:0] fail_A,
  output logic [15:0] fail_B,
  output logic [1:0]  fail_op,
  output logic [15:0] fail_exp,
  output logic [15:0] fail_got,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CHECK   = 2'b01,
    TRIPPED = 2'b10
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
`ifdef CHECKER_FLAGS_EN
    logic [3:0]  flags;
`endif
  } vec_t;

  state_t      cur, nxt;
  vec_t        cur_vec, dly;
  logic        active, compare, mismatch, trip;
  logic [15:0] add_r, gold_r, mism_next;

`ifdef CHECKER_FLAGS_EN
  logic add_c, gold_c, gold_v;
  assign {add_c, add_r} = {1'b0, A} + {1'b0, B};
`else
  logic unused_flags;
  assign unused_flags = ^{dut_carry, dut_zero, dut_overflow, dut_negative};
  assign add_r = A + B;
`endif

  always_comb begin
    gold_r = '0;
    unique case (op)
      2'b00: gold_r = add_r;
      2'b01: gold_r = A - B;
      2'b10: gold_r = A & B;
      2'b11: gold_r = A | B;
    endcase
  end

`ifdef CHECKER_FLAGS_EN
  always_comb begin
    gold_c = 1'b0;
    gold_v = 1'b0;
    unique case (op)
      2'b00: begin
        gold_c = add_c;
        gold_v = (A[15] == B[15]) && (add_r[15] != A[15]);
      end
      2'b01: begin
        gold_c = (A < B);
        gold_v = (A[15] != B[15]) && (gold_r[15] != A[15]);
      end
      default: ;
    endcase
  end
`endif

  // Vectors are only accepted once already in CHECK/TRIPPED with en high.
  assign active = en && (cur != IDLE);

  always_comb begin
    cur_vec       = '0;
    cur_vec.valid = in_valid && active;
    cur_vec.a     = A;
    cur_vec.b     = B;
    cur_vec.op    = op;
    cur_vec.res   = gold_r;
`ifdef CHECKER_FLAGS_EN
    cur_vec.flags = {gold_c, (gold_r == 16'h0000), gold_v, gold_r[15]};
`endif
  end

  generate
    if (LAT == 0) begin : g_comb
      assign dly = cur_vec;
    end else begin : g_pipe
      vec_t pipe [LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (clear || !active) begin
          for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= cur_vec;
          for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign dly = pipe[LAT-1];
    end
  endgenerate

`ifdef CHECKER_FLAGS_EN
  assign mismatch = (dly.res != dut_result) ||
                    (dly.flags != {dut_carry, dut_zero, dut_overflow, dut_negative});
`else
  assign mismatch = (dly.res != dut_result);
`endif

  assign compare   = dly.valid && active && !clear;
  assign mism_next = (mismatch && (mism_cnt != 16'hFFFF)) ? mism_cnt + 16'd1 : mism_cnt;
  assign trip      = compare && ({16'h0000, mism_next} >= ALARM_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_cnt  <= '0;
      mism_cnt   <= '0;
      alarm      <= 1'b0;
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_op    <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else if (clear) begin
      check_cnt  <= '0;
      mism_cnt   <= '0;
      alarm      <= 1'b0;
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_op    <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else if (compare) begin
      check_cnt <= check_cnt + 32'd1;
      mism_cnt  <= mism_next;
      if (trip) alarm <= 1'b1;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_A     <= dly.a;
        fail_B     <= dly.b;
        fail_op    <= dly.op;
        fail_exp   <= dly.res;
        fail_got   <= dut_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (clear) begin
      nxt = en ? CHECK : IDLE;
    end else begin
      unique case (cur)
        IDLE:    if (en) nxt = CHECK;
        CHECK: begin
          if (!en)       nxt = IDLE;
          else if (trip) nxt = TRIPPED;
        end
        TRIPPED: nxt = TRIPPED;
        default: nxt = IDLE;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_alu_16bit_resp_checker.sv
// Scoreboard bench for alu_16bit_resp_checker: a behavioural 1-cycle ALU with fault injection
// drives two checkers (ALARM_THRESH 1 and 3); expected checker state is queued per vector.
module tb_alu_16bit_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n, en, clear, in_valid;
  logic [15:0] A, B;
  logic [1:0]  op;
  logic [19:0] alu_q, fault;

  logic [31:0] check_cnt, t_check_cnt;
  logic [15:0] mism_cnt, t_mism_cnt;
  logic        alarm, t_alarm, fail_valid, t_fail_valid;
  logic [15:0] fail_A, fail_B, fail_exp, fail_got;
  logic [15:0] t_fail_A, t_fail_B, t_fail_exp, t_fail_got;
  logic [1:0]  fail_op, t_fail_op, state, t_state;

  alu_16bit_resp_checker #(.LAT(1), .ALARM_THRESH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_valid(in_valid),
    .A(A), .B(B), .op(op), .dut_result(alu_q[15:0]),
    .dut_carry(alu_q[19]), .dut_zero(alu_q[18]), .dut_overflow(alu_q[17]), .dut_negative(alu_q[16]),
    .check_cnt(check_cnt), .mism_cnt(mism_cnt), .alarm(alarm), .fail_valid(fail_valid),
    .fail_A(fail_A), .fail_B(fail_B), .fail_op(fail_op), .fail_exp(fail_exp), .fail_got(fail_got),
    .state(state)
  );

  alu_16bit_resp_checker #(.LAT(1), .ALARM_THRESH(3)) u_thr (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_valid(in_valid),
    .A(A), .B(B), .op(op), .dut_result(alu_q[15:0]),
    .dut_carry(alu_q[19]), .dut_zero(alu_q[18]), .dut_overflow(alu_q[17]), .dut_negative(alu_q[16]),
    .check_cnt(t_check_cnt), .mism_cnt(t_mism_cnt), .alarm(t_alarm), .fail_valid(t_fail_valid),
    .fail_A(t_fail_A), .fail_B(t_fail_B), .fail_op(t_fail_op), .fail_exp(t_fail_exp), .fail_got(t_fail_got),
    .state(t_state)
  );

  typedef struct {
    int          due;
    logic [31:0] cc;
    logic [15:0] mc;
    logic        al;
    logic [1:0]  st;
    logic        fv;
    logic [65:0] frec;
    logic        al3;
    logic [1:0]  st3;
  } rec_t;

  rec_t        q[$];
  int          n_err = 0, n_chk = 0, edges = 0;
  logic [31:0] m_cc;
  logic [15:0] m_mc;
  logic        m_al, m_fv, m_al3;
  logic [1:0]  m_st, m_st3;
  logic [65:0] m_frec;

  // Returns {carry, zero, overflow, negative, result}.
  function automatic logic [19:0] gold(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = '0; s = '0;
    case (o)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      2'd1: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {c, (r == 16'h0000), v, r[15], r};
  endfunction

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  always @(posedge clk) alu_q <= gold(A, B, op) ^ fault;

  always @(negedge clk) begin : mon
    rec_t r;
    while (q.size() > 0 && q[0].due <= edges) begin
      r = q.pop_front();
      chk("sb_due", 66'(edges), 66'(r.due));
      chk("check_cnt", 66'(check_cnt), 66'(r.cc));
      chk("mism_cnt", 66'(mism_cnt), 66'(r.mc));
      chk("alarm_state", 66'({alarm, state}), 66'({r.al, r.st}));
      chk("fail_valid", 66'(fail_valid), 66'(r.fv));
      chk("fail_rec", {fail_A, fail_B, fail_op, fail_exp, fail_got}, r.frec);
      chk("thr_alarm_state", 66'({t_alarm, t_state, t_mism_cnt}), 66'({r.al3, r.st3, r.mc}));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o, input logic [19:0] f);
    logic [19:0] g;
    logic        mis;
    rec_t        r;
    @(negedge clk);
    A = a; B = b; op = o; fault = f; in_valid = 1'b1;
    g = gold(a, b, o);
`ifdef CHECKER_FLAGS_EN
    mis = (f != 20'h0);
`else
    mis = (f[15:0] != 16'h0);
`endif
    m_cc = m_cc + 32'd1;
    if (mis) begin
      if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      if (!m_fv) begin
        m_fv   = 1'b1;
        m_frec = {a, b, o, g[15:0], g[15:0] ^ f[15:0]};
      end
    end
    if (m_mc >= 16'd1) begin m_al  = 1'b1; m_st  = 2'b10; end
    if (m_mc >= 16'd3) begin m_al3 = 1'b1; m_st3 = 2'b10; end
    r.due = edges + 2; r.cc = m_cc; r.mc = m_mc; r.al = m_al; r.st = m_st;
    r.fv = m_fv; r.frec = m_frec; r.al3 = m_al3; r.st3 = m_st3;
    q.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; fault = '0;
    end
  endtask

  task automatic model_reset();
    m_cc = '0; m_mc = '0; m_al = 1'b0; m_fv = 1'b0; m_al3 = 1'b0;
    m_st = 2'b01; m_st3 = 2'b01; m_frec = '0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b0; fault = '0;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  logic [15:0] dir_a [6] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0F0F};
  logic [15:0] dir_b [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0001, 16'hF0F0};
  logic [1:0]  dir_o [6] = '{2'd1,     2'd1,     2'd0,     2'd1,     2'd0,     2'd3};

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; op = '0; fault = '0;
    model_reset();
    #12;
    chk("rst_cnts", 66'({check_cnt, mism_cnt}), 66'(0));
    chk("rst_flags", 66'({alarm, fail_valid, state}), 66'(0));
    chk("rst_fail", {fail_A, fail_B, fail_op, fail_exp, fail_got}, 66'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    chk("enter_check", 66'(state), 66'(2'b01));

    for (int i = 0; i < 512; i++) send(16'($urandom), 16'($urandom), 2'd0, '0);
    for (int i = 0; i < 6; i++) send(dir_a[i], dir_b[i], dir_o[i], '0);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(16'($urandom), 16'($urandom), 2'($urandom), '0);
    end
    idle(3);

    send(16'hFFFF, 16'hFFFF, 2'd0, 20'h00001);
    send(16'h0001, 16'h0002, 2'd1, 20'h00100);
    idle(3);

    @(negedge clk);
    A = 16'h00AA; B = 16'h0055; op = 2'd3; fault = 20'h00004; in_valid = 1'b1;
    do_clear();
    chk("clr_cnts", 66'({check_cnt, mism_cnt, t_mism_cnt}), 66'(0));
    chk("clr_flags", 66'({alarm, fail_valid, t_alarm}), 66'(0));
    chk("clr_state", 66'({state, t_state}), 66'(4'b0101));

    for (int i = 1; i <= 25; i++)
      send(16'($urandom), 16'($urandom), 2'($urandom),
           (i == 5 || i == 9 || i == 20) ? 20'h00010 : 20'h0);
    idle(3);

    do_clear();
    send(16'h8000, 16'h8000, 2'd0, 20'h20000);
    idle(3);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom); op = 2'd0; fault = 20'h00001; in_valid = 1'b1;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnts", 66'({check_cnt, mism_cnt}), 66'(0));
    chk("arst_flags", 66'({alarm, fail_valid, state, t_state}), 66'(0));
    chk("arst_fail", {fail_A, fail_B, fail_op, fail_exp, fail_got}, 66'(0));
    in_valid = 1'b0;
    chk("sb_empty", 66'(q.size()), 66'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
